// File: rtl/timer_pkg.sv
// Shared definitions for the timer arbiter: FSM encoding, default width, round-robin pick.
// Pure declarations; no latency, no backpressure.
package timer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEFAULT_BITS = 16;

    // One-hot winner among the first n request bits, searching upward from ptr with wrap.
    function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [7:0] hit;
        logic       found;
        logic [3:0] sum;
        hit   = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sum = {1'b0, ptr} + 4'(k);
            if (sum >= 4'(n)) begin
                sum = sum - 4'(n);
            end
            if (k < n && !found && req[sum[2:0]]) begin
                hit[sum[2:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/timer_core.sv
// Up-counter with clear/enable and a terminal-match flag; count updates one edge after enable.
// No backpressure: the owner controls enable and clear every cycle.
module timer_core
    import timer_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            clear,
    input  logic [BITS-1:0] final_value,
    output logic [BITS-1:0] count,
    output logic            tick
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == final_value);

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin sharing of one timer: grant one cycle after request, done D+1 cycles after grant.
// Losing requesters simply wait (level held) until the timer returns to IDLE.
module timer_arbiter
    import timer_pkg::*;
#(
    parameter int BITS  = DEFAULT_BITS,
    parameter int N_REQ = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*BITS-1:0] delay,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic                  busy,
    output logic [BITS-1:0]       count
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [1:0]      state;
    logic [BITS-1:0] final_val;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   nxt_ptr;
    logic [PW-1:0]   win_idx;
    logic [7:0]      req_ext;
    logic [2:0]      ptr_ext;
    logic [7:0]      pick;
    logic            abort;
    logic            tick;
    logic            enable;
    logic            clear;

    always_comb begin
        req_ext              = '0;
        req_ext[N_REQ-1:0]   = req;
        ptr_ext              = 3'(ptr);
        pick                 = rr_pick(req_ext, ptr_ext, N_REQ);
        win_idx              = '0;
        for (int i = 0; i < 8; i++) begin
            if (pick[i] && i < N_REQ) begin
                win_idx = PW'(i);
            end
        end
    end

    // An owner dropping its request wins over a simultaneous terminal match.
    assign abort   = (state == ST_RUN) && !req[owner];
    assign enable  = (state == ST_RUN) && !abort && !tick;
    assign clear   = (state != ST_RUN) || abort;
    assign nxt_ptr = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            final_val <= '0;
            ptr       <= '0;
            owner     <= '0;
            grant     <= '0;
            done      <= '0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        final_val <= delay[int'(win_idx)*BITS +: BITS];
                        grant     <= N_REQ'(1) << win_idx;
                        owner     <= win_idx;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        grant <= '0;
                        ptr   <= nxt_ptr;
                    end else if (tick) begin
                        state <= ST_DONE;
                        done  <= grant;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    ptr   <= nxt_ptr;
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    timer_core #(
        .BITS(BITS)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .final_value(final_val),
        .count      (count),
        .tick       (tick)
    );

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: table of arbitration jobs plus hand-written corner sequences.
module tb_timer_arbiter;

    localparam int BITS  = 16;
    localparam int N_REQ = 4;

    logic                  clk;
    logic                  reset;
    logic [N_REQ-1:0]      req;
    logic [N_REQ*BITS-1:0] delay;
    logic [N_REQ-1:0]      grant;
    logic [N_REQ-1:0]      done;
    logic                  busy;
    logic [BITS-1:0]       count;

    int checks = 0;
    int errors = 0;

    timer_arbiter #(.BITS(BITS), .N_REQ(N_REQ)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .delay(delay),
        .grant(grant),
        .done (done),
        .busy (busy),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N_REQ-1:0] r;
        int               d;
        int               w;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_delays(input int d);
        for (int i = 0; i < N_REQ; i++) delay[i*BITS +: BITS] = BITS'(d);
    endtask

    // Called in IDLE with the request already driven; returns in the next IDLE cycle.
    task automatic run_job(input string nm, input int w, input int d);
        logic [N_REQ-1:0] oh;
        oh = N_REQ'(1) << w;
        step();
        chk({nm, " grant"}, 32'(grant), 32'(oh));
        chk({nm, " busy"}, 32'(busy), 32'd1);
        chk({nm, " count0"}, 32'(count), 32'd0);
        repeat (d) step();
        chk({nm, " countD"}, 32'(count), 32'(d));
        chk({nm, " no early done"}, 32'(done), 32'd0);
        step();
        chk({nm, " done"}, 32'(done), 32'(oh));
        chk({nm, " grant at done"}, 32'(grant), 32'(oh));
        step();
        chk({nm, " done cleared"}, 32'(done), 32'd0);
        chk({nm, " grant idle"}, 32'(grant), 32'd0);
        chk({nm, " busy idle"}, 32'(busy), 32'd0);
        chk({nm, " count idle"}, 32'(count), 32'd0);
    endtask

    initial begin
        int seen_done;

        vecs[0] = '{r: 4'b0001, d: 3, w: 0};
        vecs[1] = '{r: 4'b0001, d: 0, w: 0};
        vecs[2] = '{r: 4'b1001, d: 2, w: 3};
        vecs[3] = '{r: 4'b1001, d: 1, w: 0};
        vecs[4] = '{r: 4'b0110, d: 5, w: 1};
        vecs[5] = '{r: 4'b0011, d: 0, w: 0};
        vecs[6] = '{r: 4'b1100, d: 4, w: 2};
        vecs[7] = '{r: 4'b1111, d: 2, w: 3};

        reset = 1'b1;
        req   = '0;
        delay = '0;
        #2;
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk("idle no req grant", 32'(grant), 32'd0);
        chk("idle no req busy", 32'(busy), 32'd0);

        for (int v = 0; v < 8; v++) begin
            req = vecs[v].r;
            set_all_delays(vecs[v].d);
            run_job($sformatf("vec%0d", v), vecs[v].w, vecs[v].d);
        end
        req = '0;

        // Contention: all four held with delay 3, round-robin 0,1,2,3,0, grants 6 cycles apart.
        req = 4'b1111;
        set_all_delays(3);
        for (int g = 0; g < 5; g++) run_job($sformatf("rr%0d", g), g % 4, 3);
        req = '0;

        req = 4'b0001;
        set_all_delays(255);
        run_job("d255", 0, 255);
        req = '0;

        req = 4'b0100;
        set_all_delays(0);
        run_job("zero delay", 2, 0);
        set_all_delays(49_999);
        run_job("d49999", 2, 49_999);
        req = '0;

        // Abort of owner 1 at count 40 with requester 2 pending.
        req = 4'b0110;
        delay[1*BITS +: BITS] = 16'd100;
        delay[2*BITS +: BITS] = 16'd7;
        step();
        chk("abort grant1", 32'(grant), 32'b0010);
        repeat (40) step();
        chk("abort count40", 32'(count), 32'd40);
        req = 4'b0100;
        step();
        chk("abort grant off", 32'(grant), 32'd0);
        chk("abort busy off", 32'(busy), 32'd0);
        chk("abort count clr", 32'(count), 32'd0);
        chk("abort no done", 32'(done), 32'd0);
        step();
        chk("pending grant2", 32'(grant), 32'b0100);
        chk("pending count0", 32'(count), 32'd0);
        repeat (7) step();
        step();
        chk("pending done2", 32'(done), 32'b0100);
        req = '0;
        step();
        chk("pending idle", 32'(busy), 32'd0);

        // Delay shortened mid-run must not affect the latched final value.
        req = 4'b0001;
        delay[0 +: BITS] = 16'd10;
        step();
        chk("chg grant0", 32'(grant), 32'b0001);
        step();
        step();
        chk("chg count2", 32'(count), 32'd2);
        delay[0 +: BITS] = 16'd5;
        seen_done = 0;
        for (int c = 3; c <= 10; c++) begin
            step();
            if (done != 0) seen_done++;
        end
        chk("chg no done before 10", 32'(seen_done), 32'd0);
        chk("chg count10", 32'(count), 32'd10);
        step();
        chk("chg done at 10", 32'(done), 32'b0001);
        req = '0;
        step();
        chk("chg idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a job.
        req = 4'b0001;
        delay[0 +: BITS] = 16'd100;
        step();
        repeat (20) step();
        chk("pre-reset count", 32'(count), 32'd20);
        #2;
        reset = 1'b1;
        req   = '0;
        #1;
        chk("async grant", 32'(grant), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        chk("async count", 32'(count), 32'd0);
        chk("async done", 32'(done), 32'd0);
        step();
        reset = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 120; c++) begin
            step();
            if (done != 0 || busy != 0) seen_done++;
        end
        chk("no done after reset", 32'(seen_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
